// File: rtl/plexed_lane_mac.sv
// plexed_lane_mac
//   Multi-lane signed dot-product MAC with ReLU / shift / saturate
//   post-processing. It is fed by an AXI-Stream packet made of one bias beat
//   followed by data beats. Each data beat carries LANES weight/activation
//   pairs. Results pass through an internal FWFT FIFO. Input acceptance is
//   credit-throttled, so the 3-stage pipeline never has to stall.
//
// Ports
//   ACLK, ARESET     clock (rising edge), asynchronous active-high reset
//   SD_AXIS_*        input stream. TDATA holds the bias, or lane i at
//                    [2*IN_W*i +: 2*IN_W] with the weight in the upper half.
//                    On the bias beat, TUSER[0] is the ReLU enable and
//                    TUSER[12:8] is the right-shift amount.
//   MO_AXIS_*        output stream, one single-beat packet per result
module plexed_lane_mac #(
  parameter int LANES     = 2,
  parameter int IN_W      = 8,
  parameter int ACC_W     = 32,
  parameter int OUT_W     = 32,
  parameter int OUT_DEPTH = 4,
  parameter int TUSER_W   = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      SD_AXIS_TVALID,
  output logic                      SD_AXIS_TREADY,
  input  logic [2*IN_W*LANES-1:0]   SD_AXIS_TDATA,
  input  logic                      SD_AXIS_TLAST,
  input  logic [TUSER_W-1:0]        SD_AXIS_TUSER,
  output logic                      MO_AXIS_TVALID,
  input  logic                      MO_AXIS_TREADY,
  output logic [OUT_W-1:0]          MO_AXIS_TDATA,
  output logic                      MO_AXIS_TLAST
);

  localparam int PW = 2 * IN_W;          // one product / one lane slot
  localparam int DW = PW * LANES;        // beat width
  localparam int AW = $clog2(OUT_DEPTH);
  localparam int CW = AW + 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(OUT_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic {ST_BIAS, ST_DATA} pkt_state_t;

  // ---------------------------------------------------------------- input
  pkt_state_t state_q, state_d;
  logic       tready_q;
  logic       beat;
  logic       is_first;
  logic       tuser_unused;

  assign SD_AXIS_TREADY = tready_q;
  assign beat           = SD_AXIS_TVALID & tready_q;
  assign is_first       = (state_q == ST_BIAS);
  assign tuser_unused   = ^SD_AXIS_TUSER;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state_q <= ST_BIAS;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (beat) state_d = SD_AXIS_TLAST ? ST_BIAS : ST_DATA;
  end

  // Per-lane products, packed into the same slots as the input lanes.
  logic [DW-1:0] prod_vec;
  always_comb begin
    prod_vec = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      prod_vec[PW*i +: PW] = PW'($signed(SD_AXIS_TDATA[PW*i+IN_W +: IN_W])) *
                             PW'($signed(SD_AXIS_TDATA[PW*i +: IN_W]));
    end
  end

  // ------------------------------------------------------------------- S1
  // s1_data carries the raw bias on first beats and the products otherwise.
  // Both have the same width. The control fields are only used with first.
  logic          s1_valid, s1_first, s1_last, s1_relu;
  logic [4:0]    s1_shift;
  logic [DW-1:0] s1_data;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_relu  <= 1'b0;
      s1_shift <= '0;
      s1_data  <= '0;
    end else begin
      s1_valid <= beat;
      if (beat) begin
        s1_first <= is_first;
        s1_last  <= SD_AXIS_TLAST;
        s1_relu  <= SD_AXIS_TUSER[0];
        s1_shift <= SD_AXIS_TUSER[12:8];
        s1_data  <= is_first ? SD_AXIS_TDATA : prod_vec;
      end
    end
  end

  // ------------------------------------------------------------------- S2
  logic signed [ACC_W-1:0] lane_sum;
  always_comb begin
    lane_sum = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + ACC_W'($signed(s1_data[PW*i +: PW]));
    end
  end

  logic                    s2_valid, s2_first, s2_last, s2_relu;
  logic [4:0]              s2_shift;
  logic signed [ACC_W-1:0] s2_val;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_relu  <= 1'b0;
      s2_shift <= '0;
      s2_val   <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_first <= s1_first;
        s2_last  <= s1_last;
        s2_relu  <= s1_relu;
        s2_shift <= s1_shift;
        s2_val   <= s1_first ? ACC_W'($signed(s1_data)) : lane_sum;
      end
    end
  end

  // ------------------------------------------------------------------- S3
  // The control fields are latched with the bias and held for the whole packet.
  // The post stage samples acc_q/ctrl before the next packet's bias
  // overwrites them, because it is registered on the same edge.
  logic signed [ACC_W-1:0] acc_q;
  logic                    relu_q;
  logic [4:0]              shift_q;
  logic                    s3_last;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      acc_q   <= '0;
      relu_q  <= 1'b0;
      shift_q <= '0;
      s3_last <= 1'b0;
    end else begin
      s3_last <= s2_valid & s2_last;
      if (s2_valid) begin
        acc_q <= s2_first ? s2_val : acc_q + s2_val;
        if (s2_first) begin
          relu_q  <= s2_relu;
          shift_q <= s2_shift;
        end
      end
    end
  end

  // ----------------------------------------------------------------- post
  logic signed [ACC_W-1:0] relu_val, shifted;
  logic        [OUT_W-1:0] sat_val;

  always_comb begin
    relu_val = (relu_q && acc_q[ACC_W-1]) ? '0 : acc_q;
    shifted  = relu_val >>> shift_q;
    if (shifted > SAT_MAX)      sat_val = SAT_MAX[OUT_W-1:0];
    else if (shifted < SAT_MIN) sat_val = SAT_MIN[OUT_W-1:0];
    else                        sat_val = shifted[OUT_W-1:0];
  end

  logic             post_valid;
  logic [OUT_W-1:0] post_data;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      post_valid <= 1'b0;
      post_data  <= '0;
    end else begin
      post_valid <= s3_last;
      if (s3_last) post_data <= sat_val;
    end
  end

  // ----------------------------------------------------------------- FIFO
  logic [OUT_W-1:0] mem [OUT_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             fifo_empty, push, pop;

  assign fifo_empty     = (wr_ptr == rd_ptr);
  assign push           = post_valid;
  assign pop            = ~fifo_empty & MO_AXIS_TREADY;
  assign MO_AXIS_TVALID = ~fifo_empty;
  assign MO_AXIS_TLAST  = ~fifo_empty;
  assign MO_AXIS_TDATA  = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage has no reset. The output is masked while the FIFO is empty.
  always_ff @(posedge ACLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= post_data;
  end

  // -------------------------------------------------------------- credits
  // One credit per packet, from TLAST acceptance until the result is popped.
  // Holding TREADY low at OUT_DEPTH credits keeps a FIFO slot reserved
  // for every packet still in flight.
  logic [CW-1:0] credits_q, credits_d;

  assign credits_d = credits_q + CW'(beat & SD_AXIS_TLAST) - CW'(pop);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      credits_q <= '0;
      tready_q  <= 1'b0;
    end else begin
      credits_q <= credits_d;
      tready_q  <= (credits_d < CW'(OUT_DEPTH));
    end
  end

endmodule

// File: tb/tb_plexed_lane_mac.sv
module tb_plexed_lane_mac;

  localparam int LANES     = 2;
  localparam int IN_W      = 8;
  localparam int ACC_W     = 32;
  localparam int OUT_W     = 16;
  localparam int OUT_DEPTH = 4;
  localparam int TUSER_W   = 32;

  logic              ACLK = 1'b0;
  logic              ARESET = 1'b1;
  logic              SD_AXIS_TVALID = 1'b0;
  logic              SD_AXIS_TREADY;
  logic [31:0]       SD_AXIS_TDATA = '0;
  logic              SD_AXIS_TLAST = 1'b0;
  logic [31:0]       SD_AXIS_TUSER = '0;
  logic              MO_AXIS_TVALID;
  logic              MO_AXIS_TREADY = 1'b0;
  logic [OUT_W-1:0]  MO_AXIS_TDATA;
  logic              MO_AXIS_TLAST;

  plexed_lane_mac #(
    .LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W),
    .OUT_W(OUT_W), .OUT_DEPTH(OUT_DEPTH), .TUSER_W(TUSER_W)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .SD_AXIS_TVALID(SD_AXIS_TVALID), .SD_AXIS_TREADY(SD_AXIS_TREADY),
    .SD_AXIS_TDATA(SD_AXIS_TDATA), .SD_AXIS_TLAST(SD_AXIS_TLAST),
    .SD_AXIS_TUSER(SD_AXIS_TUSER),
    .MO_AXIS_TVALID(MO_AXIS_TVALID), .MO_AXIS_TREADY(MO_AXIS_TREADY),
    .MO_AXIS_TDATA(MO_AXIS_TDATA), .MO_AXIS_TLAST(MO_AXIS_TLAST)
  );

  always #5 ACLK = ~ACLK;

  int     n_cmp = 0;
  int     n_bad = 0;
  int     cyc   = 0;
  int     n_acc = 0;
  int     n_out = 0;
  int     n_exp = 0;
  longint sb_q[$];

  // reference model state
  logic   expect_bias = 1'b1;
  longint m_acc = 0;
  logic   m_relu = 1'b0;
  int     m_shift = 0;

  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] beat2(input int w0, input int a0, input int w1, input int a1);
    logic [31:0] v;
    v[7:0]   = a0[7:0];
    v[15:8]  = w0[7:0];
    v[23:16] = a1[7:0];
    v[31:24] = w1[7:0];
    return v;
  endfunction

  function automatic logic [31:0] ctl(input logic relu, input int sh);
    logic [31:0] u;
    u       = '0;
    u[0]    = relu;
    u[12:8] = sh[4:0];
    return u;
  endfunction

  function automatic longint post_proc(input longint acc, input logic relu, input int sh);
    logic signed [31:0] a32;
    longint v;
    a32 = acc[31:0];
    v = a32;
    if (relu && v < 0) v = 0;
    v = v >>> sh;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  task automatic model_beat(input logic [31:0] data, input logic [31:0] user, input logic last);
    logic signed [31:0] b;
    logic signed [7:0]  w, a;
    if (expect_bias) begin
      b = data;
      m_acc = b;
      m_relu = user[0];
      m_shift = int'(user[12:8]);
    end else begin
      for (int i = 0; i < LANES; i++) begin
        w = data[16*i+8 +: 8];
        a = data[16*i +: 8];
        m_acc = m_acc + longint'(w) * longint'(a);
      end
    end
    if (last) begin
      sb_q.push_back(post_proc(m_acc, m_relu, m_shift));
      n_exp++;
    end
    expect_bias = last;
  endtask

  // Presents a beat and leaves TVALID high afterwards. The caller must either
  // call send again or call idle without any time passing in between.
  task automatic send(input logic [31:0] data, input logic [31:0] user, input logic last,
                      output int waited);
    logic ok;
    SD_AXIS_TDATA  = data;
    SD_AXIS_TUSER  = user;
    SD_AXIS_TLAST  = last;
    SD_AXIS_TVALID = 1'b1;
    waited = 0;
    ok = 1'b0;
    while (!ok && waited < 300) begin
      @(negedge ACLK);
      if (SD_AXIS_TREADY) ok = 1'b1;
      else waited++;
    end
    if (!ok) begin
      check("accept_timeout", 0, 1);
      SD_AXIS_TVALID = 1'b0;
    end else begin
      @(posedge ACLK);
      #1;
      n_acc++;
      model_beat(data, user, last);
    end
  endtask

  task automatic idle();
    SD_AXIS_TVALID = 1'b0;
    SD_AXIS_TLAST  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb_q.size() != 0 || MO_AXIS_TVALID) && t < 400) begin
      @(negedge ACLK);
      t++;
    end
    check("drain_left", sb_q.size(), 0);
  endtask

  // output monitor / scoreboard compare
  always @(negedge ACLK) begin
    if (!ARESET && MO_AXIS_TVALID && MO_AXIS_TREADY) begin
      n_out++;
      if (sb_q.size() == 0) begin
        check("unexpected_result", longint'($signed(MO_AXIS_TDATA)), 0);
      end else begin
        check("result", longint'($signed(MO_AXIS_TDATA)), sb_q.pop_front());
        check("tlast", MO_AXIS_TLAST, 1);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic bp_done = 1'b0;

  initial begin
    int w, wsum, tl, t, base, outs;

    // reset values
    repeat (3) @(negedge ACLK);
    check("rst_tready", SD_AXIS_TREADY, 0);
    check("rst_tvalid", MO_AXIS_TVALID, 0);
    check("rst_tdata", MO_AXIS_TDATA, 0);
    check("rst_tlast", MO_AXIS_TLAST, 0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    check("tready_before_edge", SD_AXIS_TREADY, 0);
    @(negedge ACLK);
    check("tready_after_edge", SD_AXIS_TREADY, 1);
    @(posedge ACLK); #1;
    MO_AXIS_TREADY = 1'b1;

    // basic with latency
    send(32'(-600), ctl(0, 0), 1'b0, w);
    send(beat2(-50, 38, 5, 2), ctl(0, 0), 1'b1, w);
    tl = cyc;
    idle();
    t = 0;
    while (!MO_AXIS_TVALID && t < 20) begin
      @(negedge ACLK);
      t++;
    end
    check("latency", cyc - tl, 4);
    drain();

    // relu, then shift
    send(32'(-600), ctl(1, 0), 1'b0, w);
    send(beat2(-50, 38, 5, 2), ctl(0, 0), 1'b1, w);
    send(32'(1000), ctl(0, 4), 1'b0, w);
    send(beat2(100, 100, 0, 0), ctl(0, 0), 1'b1, w);
    idle();
    drain();

    // saturation
    send(32'(30000), ctl(0, 0), 1'b0, w);
    send(beat2(-128, -128, -128, -128), ctl(0, 0), 1'b1, w);
    send(32'(-30000), ctl(0, 0), 1'b0, w);
    send(beat2(-128, 127, -128, 127), ctl(0, 0), 1'b1, w);
    idle();
    drain();

    // back-to-back
    outs = n_out;
    wsum = 0;
    send(32'(10), ctl(0, 0), 1'b0, w);                 wsum += w;
    send(beat2(-13, -1, 9, 3), ctl(1, 7), 1'b0, w);    wsum += w;
    send(beat2(1, 127, 0, 0), ctl(0, 0), 1'b1, w);     wsum += w;
    send(32'(33), ctl(0, 0), 1'b0, w);                 wsum += w;
    send(beat2(1, 2, 0, 0), ctl(0, 0), 1'b1, w);       wsum += w;
    send(32'(64), ctl(0, 0), 1'b1, w);                 wsum += w;
    idle();
    check("b2b_stall_cycles", wsum, 0);
    drain();
    check("b2b_count", n_out - outs, 3);

    // backpressure
    @(posedge ACLK); #1;
    MO_AXIS_TREADY = 1'b0;
    base = n_acc;
    fork
      begin
        int wb;
        for (int k = 1; k <= 6; k++) send(32'(k), ctl(0, 0), 1'b1, wb);
        idle();
        bp_done = 1'b1;
      end
    join_none
    t = 0;
    while (n_acc - base < 4 && t < 50) begin
      @(negedge ACLK);
      t++;
    end
    @(negedge ACLK);
    check("bp_tready_low", SD_AXIS_TREADY, 0);
    repeat (8) @(negedge ACLK);
    check("bp_accepted", n_acc - base, 4);
    check("bp_tvalid", MO_AXIS_TVALID, 1);
    @(posedge ACLK); #1;
    MO_AXIS_TREADY = 1'b1;
    t = 0;
    while (!bp_done && t < 400) begin
      @(negedge ACLK);
      t++;
    end
    check("bp_done", bp_done, 1);
    drain();
    check("bp_total_accepted", n_acc - base, 6);

    // mid-packet reset
    send(32'(7), ctl(0, 0), 1'b0, w);
    send(beat2(2, 2, 0, 0), ctl(0, 0), 1'b0, w);
    idle();
    @(posedge ACLK); #1;
    ARESET = 1'b1;
    expect_bias = 1'b1;
    @(negedge ACLK);
    check("mid_rst_tready", SD_AXIS_TREADY, 0);
    check("mid_rst_tvalid", MO_AXIS_TVALID, 0);
    check("mid_rst_tdata", MO_AXIS_TDATA, 0);
    check("mid_rst_tlast", MO_AXIS_TLAST, 0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    send(32'(5), ctl(0, 0), 1'b1, w);
    idle();
    drain();
    repeat (10) @(negedge ACLK);
    check("final_queue", sb_q.size(), 0);
    check("result_count", n_out, n_exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
